// File: rtl/dk_sfx_sequencer_if.sv
// rtl/dk_sfx_sequencer_if.sv - CPU sound-latch command bus into dk_sfx_sequencer
interface dk_sfx_sequencer_if #(
  parameter int NUM_CH = 3
);
  logic              cmd_wr;
  logic [NUM_CH-1:0] cmd_data;
  logic              cmd_ack;

  modport master (
    output cmd_wr,
    output cmd_data,
    input  cmd_ack
  );

  modport slave (
    input  cmd_wr,
    input  cmd_data,
    output cmd_ack
  );
endinterface

// File: rtl/dk_sfx_sequencer.sv
// rtl/dk_sfx_sequencer.sv - sound-latch to discrete SFX enable sequencer with min on-time, cooldown and ducking
// Build option DK_SFX_ONESHOT_EN turns command bits into self-clearing triggers.
module dk_sfx_sequencer #(
  parameter int NUM_CH           = 3,
  parameter int MIN_ON_SAMPLES   = 960,
  parameter int COOLDOWN_SAMPLES = 480,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  I_RSTn,
  input  logic                  audio_clk_en,
  dk_sfx_sequencer_if.slave     cmd,
  output logic [NUM_CH-1:0]     ch_en,
  output logic [NUM_CH-1:0]     ch_duck,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COOL   = 2'd2
  } ch_state_e;

  localparam bit              HAS_COOL  = (COOLDOWN_SAMPLES > 0);
  localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_ON_SAMPLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = HAS_COOL ? CNT_W'(COOLDOWN_SAMPLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_CH-1:0] req_q, req_d;
  logic              ack_q, ack_d;
  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [NUM_CH-1:0] ch_duck_q, ch_duck_d;
  logic              busy_q, busy_d;

  // Command latch: a write always wins, including over a one-shot self-clear.
  always_comb begin
    req_d = req_q;
`ifdef DK_SFX_ONESHOT_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (audio_clk_en && (state_q[i] == ST_IDLE) && req_q[i]) begin
        req_d[i] = 1'b0;
      end
    end
`endif
    if (cmd.cmd_wr) begin
      req_d = cmd.cmd_data;
    end
    ack_d = cmd.cmd_wr;
  end

  // Per-channel FSMs; they see req_q, so a write on a tick takes effect next tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (audio_clk_en) begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (req_q[i]) begin
              state_d[i] = ST_ACTIVE;
              cnt_d[i]   = MIN_LOAD;
            end
          end
          ST_ACTIVE: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else if (!req_q[i]) begin
              if (HAS_COOL) begin
                state_d[i] = ST_COOL;
                cnt_d[i]   = COOL_LOAD;
              end else begin
                state_d[i] = ST_IDLE;
              end
            end
          end
          ST_COOL: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Enables track the next state so they change on the same edge as the FSM.
  always_comb begin
    ch_en_d = '0;
    busy_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_en_d[i] = (state_d[i] == ST_ACTIVE);
      busy_d     = busy_d | (state_d[i] != ST_IDLE);
    end
  end

  // Ducking is built from registered enables, so it trails ch_en by one clk.
  always_comb begin
    logic higher;
    higher    = 1'b0;
    ch_duck_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      ch_duck_d[i] = ch_en_q[i] & higher;
      higher       = higher | ch_en_q[i];
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      req_q     <= '0;
      ack_q     <= 1'b0;
      ch_en_q   <= '0;
      ch_duck_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      req_q     <= req_d;
      ack_q     <= ack_d;
      ch_en_q   <= ch_en_d;
      ch_duck_q <= ch_duck_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign cmd.cmd_ack = ack_q;
  assign ch_en       = ch_en_q;
  assign ch_duck     = ch_duck_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dk_sfx_sequencer.sv
// tb/tb_dk_sfx_sequencer.sv - scoreboard bench for dk_sfx_sequencer (MIN_ON=4, COOLDOWN=2, tick every 4 clk)
module tb_dk_sfx_sequencer;
  localparam int NUM_CH = 3;

  typedef struct {
    string      tag;
    logic [2:0] en;
    logic       busy;
    logic [2:0] duck;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] ch_en;
  logic [2:0] ch_duck;
  logic       busy;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       sb [$];

  dk_sfx_sequencer_if #(.NUM_CH(NUM_CH)) cmd_if ();

  dk_sfx_sequencer #(
    .NUM_CH(NUM_CH),
    .MIN_ON_SAMPLES(4),
    .COOLDOWN_SAMPLES(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .I_RSTn(rst_n),
    .audio_clk_en(tick),
    .cmd(cmd_if),
    .ch_en(ch_en),
    .ch_duck(ch_duck),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_run(input string tag, input int n, input logic [2:0] en,
                                   input logic busy_e, input logic [2:0] duck);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.tag  = $sformatf("%s#%0d", tag, sb.size());
      e.en   = en;
      e.busy = busy_e;
      e.duck = duck;
      sb.push_back(e);
    end
  endfunction

  // Monitor: enables/busy sampled one half-clk after each tick, duck one clk later.
  initial begin
    exp_t       e;
    logic       have;
    logic [2:0] en_s;
    logic       busy_s;
    forever begin
      @(posedge clk);
      if (tick && rst_n) begin
        @(negedge clk);
        have = (sb.size() > 0);
        if (have) e = sb.pop_front();
        en_s   = ch_en;
        busy_s = busy;
        @(negedge clk);
        if (have) begin
          check_eq({e.tag, "/en"}, 32'(en_s), 32'(e.en));
          check_eq({e.tag, "/busy"}, 32'(busy_s), 32'(e.busy));
          check_eq({e.tag, "/duck"}, 32'(ch_duck), 32'(e.duck));
        end
      end
    end
  end

  task automatic after_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(posedge clk);
      if (tick) seen = 1'b1;
    end
    if (!seen) check_eq("tick_timeout", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic after_ticks(input int n);
    for (int i = 0; i < n; i++) after_tick();
  endtask

  task automatic do_write(input logic [2:0] data, input string tag);
    cmd_if.cmd_data = data;
    cmd_if.cmd_wr   = 1'b1;
    @(negedge clk);
    check_eq({tag, "/ack"}, 32'(cmd_if.cmd_ack), 32'd1);
    cmd_if.cmd_wr = 1'b0;
    @(negedge clk);
    check_eq({tag, "/ack_off"}, 32'(cmd_if.cmd_ack), 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      check_eq({tag, "/drain"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_wr   = 1'b0;
    cmd_if.cmd_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    after_ticks(2);
    check_eq("rst/en", 32'(ch_en), 32'd0);
    check_eq("rst/duck", 32'(ch_duck), 32'd0);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/ack", 32'(cmd_if.cmd_ack), 32'd0);

    // Reset while channel 0 is mid-sound.
    after_tick();
    do_write(3'b001, "t1_w");
    after_ticks(2);
    check_eq("t1/en_before", 32'(ch_en), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t1/en_async", 32'(ch_en), 32'd0);
    check_eq("t1/busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    after_ticks(2);
    check_eq("t1/busy_after", 32'(busy), 32'd0);
    check_eq("t1/en_after", 32'(ch_en), 32'd0);

    // Short request: exactly 4 on-ticks then 2 cooldown ticks.
    after_tick();
    push_run("t2", 4, 3'b001, 1'b1, 3'b000);
    push_run("t2", 2, 3'b000, 1'b1, 3'b000);
    push_run("t2", 1, 3'b000, 1'b0, 3'b000);
    do_write(3'b001, "t2_w1");
    after_tick();
    do_write(3'b000, "t2_w0");
    drain("t2");

`ifndef DK_SFX_ONESHOT_EN
    // Sustain for 10 ticks.
    after_tick();
    push_run("t3", 10, 3'b001, 1'b1, 3'b000);
    push_run("t3", 2, 3'b000, 1'b1, 3'b000);
    push_run("t3", 1, 3'b000, 1'b0, 3'b000);
    do_write(3'b001, "t3_w1");
    after_ticks(10);
    do_write(3'b000, "t3_w0");
    drain("t3");
`endif

    // Re-request during cooldown is deferred until after IDLE.
    after_tick();
    push_run("t4", 4, 3'b001, 1'b1, 3'b000);
    push_run("t4", 2, 3'b000, 1'b1, 3'b000);
    push_run("t4", 1, 3'b000, 1'b0, 3'b000);
    push_run("t4", 4, 3'b001, 1'b1, 3'b000);
    push_run("t4", 2, 3'b000, 1'b1, 3'b000);
    push_run("t4", 1, 3'b000, 1'b0, 3'b000);
    do_write(3'b001, "t4_w1");
    after_tick();
    do_write(3'b000, "t4_w0");
    after_ticks(4);
    do_write(3'b001, "t4_w2");
    after_ticks(3);
    do_write(3'b000, "t4_w3");
    drain("t4");

`ifndef DK_SFX_ONESHOT_EN
    // Priority ducking between ch2 and ch0.
    after_tick();
    push_run("t5", 4, 3'b101, 1'b1, 3'b001);
    push_run("t5", 1, 3'b001, 1'b1, 3'b000);
    push_run("t5", 2, 3'b000, 1'b1, 3'b000);
    push_run("t5", 1, 3'b000, 1'b0, 3'b000);
    do_write(3'b101, "t5_w1");
    after_tick();
    check_eq("t5/duck_lag", 32'(ch_duck), 32'd0);
    do_write(3'b001, "t5_w2");
    after_ticks(4);
    check_eq("t5/en_ch2_off", 32'(ch_en), 32'd1);
    check_eq("t5/duck_hold", 32'(ch_duck), 32'd1);
    do_write(3'b000, "t5_w3");
    drain("t5");
`endif

    // Write coincident with a tick: the FSM sees it one tick later.
    after_tick();
    repeat (3) @(negedge clk);
    #1;
    push_run("t6", 1, 3'b000, 1'b0, 3'b000);
    push_run("t6", 4, 3'b010, 1'b1, 3'b000);
    push_run("t6", 2, 3'b000, 1'b1, 3'b000);
    push_run("t6", 3, 3'b000, 1'b0, 3'b000);
    do_write(3'b010, "t6_wr_tick");
`ifndef DK_SFX_ONESHOT_EN
    after_tick();
    do_write(3'b000, "t6_w0");
`endif
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dk_sfx_sequencer.md
Name: dk_sfx_sequencer

Overview:
- Sequences the discrete sound-effect circuits (walk, jump, boom, ...) from CPU sound-latch writes.
- Converts latched command bits into per-channel enable levels, e.g. walk_en into the walk circuit, with a guaranteed minimum on-time and a post-sound retrigger lockout.
- Arbitrates channel priority by producing duck flags for the output mixer.
- Sits between the CPU sound-latch decode and the discrete sound modules. It runs on the audio sample tick.

Parameters:
- NUM_CH, 3, number of sound channels. Higher index has higher priority.
- MIN_ON_SAMPLES, 960, minimum enable duration in audio ticks (10 ms at 96 kHz). Must be >= 1.
- COOLDOWN_SAMPLES, 480, lockout after release, in audio ticks. 0 means no cooldown.
- CNT_W, 16, width of each channel's counter. Must hold max(MIN_ON_SAMPLES, COOLDOWN_SAMPLES) - 1.

Ports:
- clk  in  1  system clock
- I_RSTn  in  1  asynchronous active-low reset
- audio_clk_en  in  1  one-clk sample tick; all FSMs advance only on this
- cmd_wr  in  1  one-clk strobe; latch cmd_data
- cmd_data  in  NUM_CH  requested sound bits, 1 = play
- cmd_ack  out  1  one-clk pulse, the cycle after cmd_wr
- ch_en  out  NUM_CH  per-channel enable levels to the discrete circuits
- ch_duck  out  NUM_CH  channel active while a higher-priority channel is active
- busy  out  1  any channel not IDLE

Behaviour:
Clock, reset and command latch
- One clock. Reset is asynchronous and active-low on I_RSTn.
- Reset values: all outputs 0, req register 0, all channels IDLE, all counters 0.
- Reset asserted mid-sound forces ch_en low immediately. No cooldown is applied after reset.
- req[NUM_CH-1:0] loads cmd_data on any clk edge where cmd_wr=1, independent of audio_clk_en.
- cmd_ack is registered: high exactly the cycle after cmd_wr. Back-to-back cmd_wr gives back-to-back acks. The last write wins.
- If cmd_wr and audio_clk_en occur in the same cycle, the FSMs evaluate the old req. The new value is seen on the next tick.

Per-channel FSM (independent; transitions only when audio_clk_en=1)
- IDLE: if req[i]=1, go to ACTIVE, load cnt=MIN_ON_SAMPLES-1, set ch_en[i]=1 on the same edge.
- ACTIVE: if cnt!=0, decrement. If cnt==0 and req[i]=1, stay ACTIVE with cnt held at 0 (sustain).
- ACTIVE, cnt==0 and req[i]=0:
  - COOLDOWN_SAMPLES>0: go to COOLDOWN, load cnt=COOLDOWN_SAMPLES-1, clear ch_en[i].
  - COOLDOWN_SAMPLES=0: go straight to IDLE, clear ch_en[i].
- Clearing req[i] before the minimum expires does not shorten the on-time.
- COOLDOWN: req[i] is ignored. Decrement cnt; at cnt==0 go to IDLE.
- A req[i] still set at the end of cooldown re-enters ACTIVE on the following tick.
- Resulting on-time: ch_en[i] high for exactly MIN_ON_SAMPLES ticks when the request is shorter than that.
- Counters never wrap. They are decremented only when non-zero.

Outputs
- ch_duck[i] is registered and updated every clk: ch_en[i] & (OR of ch_en[NUM_CH-1:i+1]). It therefore lags ch_en by one clk.
- ch_duck[NUM_CH-1] is always 0.
- busy is registered: OR over channels of (state != IDLE).

Optional Feature:
DK_SFX_ONESHOT_EN
- Defined: command bits are self-clearing triggers. req[i] clears on the tick where channel i enters ACTIVE, so every trigger plays exactly MIN_ON_SAMPLES ticks and sustain never occurs.
- If cmd_wr sets req[i] in that same cycle, the write wins.
- A trigger written during ACTIVE or COOLDOWN is held and replays after cooldown.
- Not defined: level semantics as above, and req changes only on cmd_wr.

Test Plan:
Bench uses MIN_ON_SAMPLES=4, COOLDOWN_SAMPLES=2, NUM_CH=3, and an audio_clk_en pulse every 4 clk.
1. Reset with no commands -> ch_en=0, ch_duck=0, busy=0, cmd_ack=0. Assert I_RSTn=0 while ch0 is ACTIVE -> ch_en[0]=0 asynchronously; after release busy=0.
2. cmd_data=3'b001 then, 1 tick later, 3'b000 -> ch_en[0] high for exactly 4 ticks, then 2 cooldown ticks with busy=1, then busy=0. cmd_ack high 1 clk after each write.
3. Hold cmd_data=3'b001 for 10 ticks, then write 0 -> ch_en[0] high 10 ticks (sustain), low on the first tick after the release is seen, then cooldown of 2 ticks.
4. Release then re-request 3'b001 during cooldown -> ch_en[0] stays low through both cooldown ticks, then rises 1 tick after IDLE is reached.
5. cmd_data=3'b101 -> ch_en=101 on the same tick; ch_duck=001 one clk later. Write 3'b001 -> after ch2 times out, ch_duck[0] drops 1 clk after ch_en[2] falls.
6. cmd_wr coincident with audio_clk_en while IDLE -> no ch_en change that tick; ch_en rises on the next tick. With DK_SFX_ONESHOT_EN, a single 3'b010 write -> ch_en[1] high exactly 4 ticks and req[1]=0 afterwards.
